// File: rtl/uart_autobaud.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_autobaud
//
// Measures the bit period of an incoming 0x55 sync character (8N1, LSB first)
// and produces the divisor for the baud tick generator. The generator counts
// 0..count_max, so count_max is the bit period in clk cycles minus 1.
//
// The five falling edges of 0x55 are two bit periods apart. The first interval
// is the reference; the others must fall within 25 % of it. The edge-1 to
// edge-5 distance (eight bit periods) is rounded to one bit period. The low
// bit 7 must then end with a rising edge before the result is committed.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   rx         asynchronous serial line, idle high
//   enable     level: 1 arms detection, 0 aborts and parks in IDLE
//   count_max  measured bit period - 1, held between detections
//   locked     1 once any detection has succeeded since reset
//   busy       1 in any state other than IDLE
//   done       one-cycle pulse on a successful detection
//   error      one-cycle pulse on a rejected frame
// -----------------------------------------------------------------------------
module uart_autobaud #(
    parameter int CNT_W             = 24,
    parameter int MIN_BIT           = 8,
    parameter int IDLE_CYC          = 16,
    parameter int DEFAULT_COUNT_MAX = 5207
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx,
    input  logic             enable,
    output logic [CNT_W-4:0] count_max,
    output logic             locked,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int EST_W  = CNT_W - 3;
    localparam int IDLE_W = $clog2(IDLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_WAIT_START,
        S_MEASURE,
        S_WAIT_STOP
    } state_t;

    // rx synchroniser and edge detector
    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic fall, rise;

    // FSM state and datapath
    state_t            state_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  seg_q;
    logic [CNT_W-1:0]  ref_q;
    logic [2:0]        fe_cnt_q;
    logic [EST_W-1:0]  bit_est_q;
    logic              arm_q;
    logic [EST_W-1:0]  count_max_q;
    logic              locked_q, busy_q, done_q, error_q;

    // Combinational helpers
    logic [CNT_W-1:0] seg_inc, total_inc, seg_diff;
    logic [CNT_W:0]   seg_limit, est_sum, est_shift;
    logic [EST_W:0]   stop_limit;
    logic [EST_W-1:0] bit_est_new;
    logic             in_tol, seg_late, stop_late, total_ovf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall = rx_prev_q & ~rx_s_q;
    assign rise = ~rx_prev_q & rx_s_q;

    // Counter values including the current cycle, so an interval taken at an
    // edge equals the true cycle distance between the two edges.
    assign seg_inc   = seg_q + CNT_W'(1);
    assign total_inc = total_q + CNT_W'(1);
    assign total_ovf = (total_inc == '1);

    assign seg_diff  = (seg_inc >= ref_q) ? (seg_inc - ref_q) : (ref_q - seg_inc);
    assign in_tol    = (seg_diff <= (ref_q >> 2));
    assign seg_limit = {1'b0, ref_q} + {2'b00, ref_q[CNT_W-1:1]};
    assign seg_late  = ({1'b0, seg_inc} > seg_limit);

    // Round eight bit periods to one; saturate rather than wrap near overflow.
    assign est_sum     = {1'b0, total_inc} + (CNT_W+1)'(4);
    assign est_shift   = est_sum >> 3;
    assign bit_est_new = (|est_shift[CNT_W:EST_W]) ? '1 : est_shift[EST_W-1:0];

    assign stop_limit = {1'b0, bit_est_q} + {2'b00, bit_est_q[EST_W-1:1]};
    assign stop_late  = (seg_inc > {2'b00, stop_limit});

    // NOTE: every register here is written with <= so all updates in a cycle
    // see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idle_cnt_q  <= '0;
            total_q     <= '0;
            seg_q       <= '0;
            ref_q       <= '0;
            fe_cnt_q    <= '0;
            bit_est_q   <= '0;
            arm_q       <= 1'b1;
            count_max_q <= EST_W'(DEFAULT_COUNT_MAX);
            locked_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;

            // A completed detection is re-armed only by a low enable, so a
            // permanently high enable yields exactly one measurement.
            if (!enable) begin
                arm_q <= 1'b1;
            end

            if (!enable) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (arm_q) begin
                            state_q    <= S_WAIT_IDLE;
                            busy_q     <= 1'b1;
                            idle_cnt_q <= '0;
                        end
                    end

                    S_WAIT_IDLE: begin
                        if (!rx_s_q) begin
                            idle_cnt_q <= '0;
                        end else if (idle_cnt_q == IDLE_W'(IDLE_CYC - 1)) begin
                            state_q <= S_WAIT_START;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                        end
                    end

                    S_WAIT_START: begin
                        if (fall) begin
                            total_q  <= '0;
                            seg_q    <= '0;
                            fe_cnt_q <= 3'd1;
                            state_q  <= S_MEASURE;
                        end
                    end

                    S_MEASURE: begin
                        total_q <= total_inc;
                        seg_q   <= seg_inc;
                        if (total_ovf) begin
                            error_q    <= 1'b1;
                            state_q    <= S_WAIT_IDLE;
                            idle_cnt_q <= '0;
                        end else if (fall) begin
                            if (fe_cnt_q == 3'd1) begin
                                if (seg_inc < CNT_W'(2 * MIN_BIT)) begin
                                    error_q    <= 1'b1;
                                    state_q    <= S_WAIT_IDLE;
                                    idle_cnt_q <= '0;
                                end else begin
                                    ref_q    <= seg_inc;
                                    seg_q    <= '0;
                                    fe_cnt_q <= 3'd2;
                                end
                            end else if (!in_tol) begin
                                error_q    <= 1'b1;
                                state_q    <= S_WAIT_IDLE;
                                idle_cnt_q <= '0;
                            end else if (fe_cnt_q == 3'd4) begin
                                // Fifth falling edge: total spans eight bits.
                                bit_est_q <= bit_est_new;
                                seg_q     <= '0;
                                state_q   <= S_WAIT_STOP;
                            end else begin
                                seg_q    <= '0;
                                fe_cnt_q <= fe_cnt_q + 3'd1;
                            end
                        end else if (fe_cnt_q == 3'd1 && rise && seg_inc < CNT_W'(MIN_BIT)) begin
                            // Start bit shorter than MIN_BIT: a glitch, not a frame.
                            error_q    <= 1'b1;
                            state_q    <= S_WAIT_IDLE;
                            idle_cnt_q <= '0;
                        end else if (fe_cnt_q != 3'd1 && seg_late) begin
                            error_q    <= 1'b1;
                            state_q    <= S_WAIT_IDLE;
                            idle_cnt_q <= '0;
                        end
                    end

                    S_WAIT_STOP: begin
                        seg_q <= seg_inc;
                        if (rise) begin
                            count_max_q <= bit_est_q - EST_W'(1);
                            locked_q    <= 1'b1;
                            done_q      <= 1'b1;
                            arm_q       <= 1'b0;
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                        end else if (stop_late) begin
                            error_q    <= 1'b1;
                            state_q    <= S_WAIT_IDLE;
                            idle_cnt_q <= '0;
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count_max = count_max_q;
    assign locked    = locked_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_uart_autobaud.sv
`timescale 1ns/1ps
// Testbench for uart_autobaud: drives 8N1 frames on rx and checks done/error
// pulses against a scoreboard of expected results, plus inline state checks.
module tb_uart_autobaud;

    localparam int CNT_W  = 24;
    localparam int CM_W   = CNT_W - 3;
    localparam int DEF_CM = 5207;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            rx;
    logic            enable;
    logic [CM_W-1:0] count_max;
    logic            locked, busy, done, error;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit              is_done;
        logic [CM_W-1:0] cm;
        logic            lk;
    } exp_t;

    exp_t sb_q[$];

    uart_autobaud #(
        .CNT_W(CNT_W),
        .MIN_BIT(8),
        .IDLE_CYC(16),
        .DEFAULT_COUNT_MAX(DEF_CM)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx(rx),
        .enable(enable),
        .count_max(count_max),
        .locked(locked),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every done/error pulse must match the oldest entry.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && (done === 1'b1 || error === 1'b1)) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: done=%0b error=%0b, required no pulse", done, error);
            end else begin
                e = sb_q.pop_front();
                if (done !== e.is_done || error !== !e.is_done) begin
                    bad++;
                    $display("FAIL pulse_kind: done=%0b error=%0b, required done=%0b", done, error, e.is_done);
                end
                total++;
                if (count_max !== e.cm) begin
                    bad++;
                    $display("FAIL pulse_count_max: got %0d, required %0d", count_max, e.cm);
                end
                total++;
                if (locked !== e.lk) begin
                    bad++;
                    $display("FAIL pulse_locked: got %0b, required %0b", locked, e.lk);
                end
            end
        end
    end

    // Bench-side model of the measurement: start + seven data bits span four
    // bits of length a and four of length b; round to one bit, minus 1.
    function automatic logic [CM_W-1:0] model_cm(input int a, input int b);
        int tot;
        tot = 4 * a + 4 * b;
        return CM_W'(((tot + 4) >> 3) - 1);
    endfunction

    task automatic push_done(input logic [CM_W-1:0] cm);
        exp_t e;
        e.is_done = 1'b1; e.cm = cm; e.lk = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic push_error(input logic [CM_W-1:0] cm, input logic lk);
        exp_t e;
        e.is_done = 1'b0; e.cm = cm; e.lk = lk;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic rearm();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
    endtask

    // Even-indexed bits (start, b1, b3, b5, b7) last a cycles, odd ones b.
    task automatic send_frame(input logic [7:0] data, input int a, input int b);
        logic [9:0] bits;
        bits = {1'b1, data, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = bits[k];
            repeat ((k % 2 == 0) ? a : b) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d expected pulse(s) missing after %0d cycles, required 0", name, sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (count_max !== CM_W'(DEF_CM)) begin bad++; $display("FAIL rst_count_max: got %0d, required %0d", count_max, DEF_CM); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %0b, required 0", locked); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b, required 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b, required 0", done); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_error: got %0b, required 0", error); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy: got %0b, required 0", busy); end
    endtask

    task automatic test_reject_pattern();
        enable = 1'b1;
        idle(100);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL armed_busy: got %0b, required 1", busy); end
        push_error(CM_W'(DEF_CM), 1'b0);
        send_frame(8'h0F, 200, 200);
        drain(2000, "reject_0f");
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL retry_busy: got %0b, required 1", busy); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reject_locked: got %0b, required 0", locked); end
        idle(30);
        push_done(model_cm(200, 200));
        send_frame(8'h55, 200, 200);
        drain(1000, "retry_200");
        total++; if (count_max !== CM_W'(199)) begin bad++; $display("FAIL cm_200: got %0d, required 199", count_max); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_busy: got %0b, required 0", busy); end
    endtask

    task automatic test_too_fast();
        rearm();
        idle(30);
        push_error(CM_W'(199), 1'b1);
        send_frame(8'h55, 3, 3);
        drain(50, "fast_3");
        idle(40);
        push_error(CM_W'(199), 1'b1);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        drain(100, "glitch_4");
        idle(40);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy: got %0b, required 1", busy); end
        total++; if (count_max !== CM_W'(199)) begin bad++; $display("FAIL glitch_cm: got %0d, required 199", count_max); end
    endtask

    task automatic test_lock_5208();
        rearm();
        idle(100);
        push_done(model_cm(5208, 5208));
        send_frame(8'h55, 5208, 5208);
        drain(20000, "lock_5208");
        total++; if (count_max !== CM_W'(5207)) begin bad++; $display("FAIL cm_5208: got %0d, required 5207", count_max); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL locked_5208: got %0b, required 1", locked); end
        // enable stays high: a second frame must not produce another result
        send_frame(8'h55, 101, 101);
        idle(30);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_busy: got %0b, required 0", busy); end
        total++; if (count_max !== CM_W'(5207)) begin bad++; $display("FAIL hold_cm: got %0d, required 5207", count_max); end
    endtask

    task automatic test_rates();
        rearm();
        idle(30);
        push_done(model_cm(101, 101));
        send_frame(8'h55, 101, 101);
        drain(1000, "rate_101");
        total++; if (count_max !== CM_W'(100)) begin bad++; $display("FAIL cm_101: got %0d, required 100", count_max); end
        rearm();
        idle(30);
        push_done(model_cm(101, 102));
        send_frame(8'h55, 101, 102);
        drain(1000, "rate_101_5");
        total++; if (count_max !== CM_W'(101)) begin bad++; $display("FAIL cm_101_5: got %0d, required 101", count_max); end
    endtask

    task automatic test_abort();
        rearm();
        idle(30);
        fork
            send_frame(8'h55, 150, 150);
            begin
                // third falling edge is driven 600 cycles into the frame
                repeat (610) @(negedge clk);
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy: got %0b, required 1", busy); end
                enable = 1'b0;
                @(negedge clk);
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b, required 0", busy); end
            end
        join
        idle(20);
        total++; if (count_max !== CM_W'(101)) begin bad++; $display("FAIL abort_cm: got %0d, required 101", count_max); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL abort_locked: got %0b, required 1", locked); end
        enable = 1'b1;
        idle(30);
        push_done(model_cm(150, 150));
        send_frame(8'h55, 150, 150);
        drain(1000, "after_abort");
        total++; if (count_max !== CM_W'(149)) begin bad++; $display("FAIL cm_150: got %0d, required 149", count_max); end
    endtask

    task automatic test_reset_mid();
        rearm();
        idle(30);
        fork
            send_frame(8'h55, 434, 434);
            begin
                repeat (434 * 2 + 10) @(negedge clk);
                reset_n = 1'b0;
                #1;
                total++; if (count_max !== CM_W'(DEF_CM)) begin bad++; $display("FAIL mid_rst_cm: got %0d, required %0d", count_max, DEF_CM); end
                total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_rst_locked: got %0b, required 0", locked); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %0b, required 0", busy); end
            end
        join
        @(negedge clk);
        reset_n = 1'b1;
        idle(30);
        push_done(model_cm(434, 434));
        send_frame(8'h55, 434, 434);
        drain(2000, "rate_434");
        total++; if (count_max !== CM_W'(433)) begin bad++; $display("FAIL cm_434: got %0d, required 433", count_max); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL locked_434: got %0b, required 1", locked); end
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 200000 cycles, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        rx      = 1'b1;
        test_reset();
        test_reject_pattern();
        test_too_fast();
        test_lock_5208();
        test_rates();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_autobaud.md
Name: uart_autobaud

Overview:
- Measures the bit period of an incoming UART line and produces the divisor the team's baud tick generator consumes.
- The host sends the sync character 0x55 ('U') as 8N1, LSB first.
- The block times the five falling edges of that frame, checks that they are evenly spaced, and outputs `count_max`.
- `count_max` uses the generator's convention: it equals the bit period in clk cycles minus 1.
- Sits between the rx pin and the baud generator's divisor input in the UART system.

Parameters:
- CNT_W, 24: width of the total-period counter; `count_max` is CNT_W-3 bits wide.
- MIN_BIT, 8: minimum accepted bit period in clk cycles; faster lines are rejected as glitches.
- IDLE_CYC, 16: consecutive high rx cycles required before a start edge is accepted.
- DEFAULT_COUNT_MAX, 5207: reset value of `count_max` (9600 baud at 50 MHz).

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- rx, input, 1: asynchronous serial line, idle high.
- enable, input, 1: level; 1 arms detection, 0 aborts and parks the block in IDLE.
- count_max, output, CNT_W-3: measured bit period minus 1; holds its value between detections.
- locked, output, 1: 1 once any detection has succeeded since reset.
- busy, output, 1: 1 in any state other than IDLE.
- done, output, 1: one-cycle pulse on successful detection.
- error, output, 1: one-cycle pulse on a rejected frame.

Behaviour:
- **rx synchronisation**
  - rx passes through a 2-flop synchroniser, giving rx_s; rx_s resets to 1.
  - Edge detect compares rx_s with a 1-cycle delayed copy.
  - All timing below is in cycles of edge detection, which lags the pin by 3 cycles.
- **Reset values:** count_max = DEFAULT_COUNT_MAX, locked = 0, busy = 0, done = 0, error = 0, state = IDLE.
- **IDLE**
  - Moves to WAIT_IDLE when enable = 1.
- **WAIT_IDLE**
  - Counts consecutive cycles with rx_s = 1; the count clears on any 0.
  - At IDLE_CYC consecutive highs, moves to WAIT_START.
- **WAIT_START**
  - On a falling edge: clear `total` and `seg`, set fe_cnt = 1, move to MEASURE.
- **MEASURE**
  - Every cycle: total += 1 and seg += 1.
  - On each falling edge, fe_cnt increments; the value of `seg` at that edge is the interval (nominally 2 bit periods). Then seg is cleared.
  - Interval 1 (fe_cnt becomes 2) is stored as `ref`. It must satisfy ref >= 2*MIN_BIT, otherwise error.
  - Intervals 2 to 4 must satisfy |seg - ref| <= ref>>2, otherwise error.
  - At the 5th falling edge, `total` equals the cycle distance from edge 1 to edge 5, nominally 8 bit periods.
    - bit_est = (total + 4) >> 3, i.e. round to nearest.
    - Move to WAIT_STOP.
  - Overflow: if total reaches all-ones, raise error.
  - Timeout: if seg exceeds ref + (ref>>1) after interval 1, raise error.
- **WAIT_STOP**
  - bit 7 is low and must end with a rising edge within bit_est + (bit_est>>1) cycles of edge 5.
  - On that rising edge:
    - count_max <= bit_est - 1.
    - locked <= 1.
    - done pulses on the same cycle count_max updates.
    - Move to IDLE.
  - On timeout: error.
- **error**
  - error pulses for 1 cycle.
  - count_max and locked are unchanged.
  - Next state is WAIT_IDLE if enable = 1, else IDLE (automatic retry).
- **Re-arming after done**
  - From IDLE, a new detection starts only after enable has been observed low for at least 1 cycle.
  - Holding enable high therefore yields exactly one measurement.
- **enable = 0 in any state:** move to IDLE next cycle, no done or error pulse, outputs held.
- **Priority:** reset_n > enable = 0 > error > done.
- **reset_n asserted mid-frame:** all outputs return to reset values immediately (asynchronous).
- **Arithmetic**
  - Interval comparisons use unsigned CNT_W-bit arithmetic.
  - bit_est - 1 never underflows, since bit_est >= MIN_BIT.

Test Plan:
1. enable = 1, line idle 100 cycles, send 0x55 at 5208 cycles/bit → one done pulse, count_max = 5207, locked = 1, no error.
2. 0x55 at 101 cycles/bit (total = 808, bit_est = 101) → count_max = 100. Repeat at 101.5 cycles/bit by alternating 101/102-cycle bits (total 812) → bit_est = 102, count_max = 101.
3. Send 0x0F at 200 cycles/bit → error pulse; count_max stays 5207, locked = 0; block returns to WAIT_IDLE. A following 0x55 at 200 cycles/bit → done, count_max = 199.
4. 0x55 at 3 cycles/bit (below MIN_BIT = 8) → error, no done. A 4-cycle low glitch on an idle line → error, no done.
5. Drop enable after the 3rd falling edge → busy = 0 next cycle, no done or error, count_max unchanged. Re-raise enable and send a valid frame → done.
6. Assert reset_n = 0 mid-MEASURE after one successful lock → count_max = 5207, locked = 0, busy = 0 asynchronously. After release with enable = 1, a valid 0x55 at 434 cycles/bit → count_max = 433.
